// File: rtl/pim_result_accumulator_pkg.sv
// pim_result_accumulator_pkg: shared sizes and state encoding for the result accumulator
package pim_result_accumulator_pkg;
  localparam int WIDTH = 8;
  localparam int CHUNK_SIZE = 2;
  localparam int PIM_UNIT_CAPACITY = 16;
  localparam int NUM_PIM_UNITS = 4;
  localparam int ELEMS = CHUNK_SIZE * CHUNK_SIZE;
  localparam int IDX_W = $clog2(ELEMS);
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} acc_state_t;
endpackage

// File: rtl/pim_result_accumulator_if.sv
// pim_result_accumulator_if: element stream from the accumulator to the output writer
interface pim_result_accumulator_if;
  import pim_result_accumulator_pkg::*;
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;
  logic [IDX_W-1:0] idx;
  logic             last;
  modport master (output valid, data, idx, last, input ready);
  modport slave (input valid, data, idx, last, output ready);
endinterface

// File: rtl/pim_result_accumulator_sum_tree.sv
// pim_sum_tree: combinational per-element sum of all valid unit results in one cycle
module pim_sum_tree
  import pim_result_accumulator_pkg::*;
#(
  parameter int N = NUM_PIM_UNITS
) (
  input  logic [N-1:0]             valid,
  input  logic [N*ELEMS*WIDTH-1:0] data,
  output logic [ELEMS*WIDTH-1:0]   sum
);
  always_comb begin
    sum = '0;
    for (int e = 0; e < ELEMS; e++)
      for (int u = 0; u < N; u++)
        sum[e*WIDTH +: WIDTH] = sum[e*WIDTH +: WIDTH] + (valid[u] ? data[(u*ELEMS+e)*WIDTH +: WIDTH] : '0);
  end
endmodule

// File: rtl/pim_result_accumulator.sv
// pim_result_accumulator: sums K-slice partial products per chunk, then streams the chunk out
module pim_result_accumulator
  import pim_result_accumulator_pkg::*;
#(
  parameter int NUM_UNITS = NUM_PIM_UNITS
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [15:0]                      num_slices,
  input  logic [NUM_UNITS-1:0]             unit_valid,
  input  logic [NUM_UNITS*ELEMS*WIDTH-1:0] unit_result,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  pim_result_accumulator_if.master         o
);
  acc_state_t                       state, state_n;
  logic [ELEMS-1:0][WIDTH-1:0]      acc;
  logic [ELEMS*WIDTH-1:0]           sum;
  logic [15:0]                      remaining, n;
  logic [IDX_W-1:0]                 idx;
  logic                             accept, take, hs, last, err_n;
  pim_sum_tree #(.N(NUM_UNITS)) u_sum (.valid(unit_valid), .data(unit_result), .sum(sum));
  assign n       = 16'($countones(unit_valid));
  assign accept  = (state == IDLE) && start;
  assign take    = (state == ACCUM) && (n <= remaining);
  assign last    = idx == IDX_W'(ELEMS - 1);
  assign hs      = o.valid && o.ready;
  assign busy    = state != IDLE;
  assign o.valid = state == DRAIN;
  assign o.data  = acc[idx];
  assign o.idx   = idx;
  assign o.last  = o.valid && last;
  // An oversubscribed cycle is dropped whole; the units cannot be stalled, so err is the only trace.
  assign err_n   = (accept ? 1'b0 : err) | (|unit_valid && !take);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? (num_slices == '0 ? DRAIN : ACCUM) : IDLE;
      ACCUM:   state_n = (take && n == remaining) ? DRAIN : ACCUM;
      DRAIN:   state_n = (hs && last) ? IDLE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      idx       <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_n;
      done  <= hs && last;
      err   <= err_n;
      if (accept) begin
        acc       <= '0;
        remaining <= num_slices;
      end else if (take) begin
        for (int e = 0; e < ELEMS; e++) acc[e] <= acc[e] + sum[e*WIDTH +: WIDTH];
        remaining <= remaining - n;
      end
      if (hs) idx <= last ? '0 : idx + 1'b1;
    end
  end
endmodule
